round_state_reg: RTL and testbench

State register and round sequencer at the head of the Ascon permutation datapath. Holds the 320-bit Ascon state (type_state, five 64-bit words), drives the constant-addition stage with the current state and the round index, and loops the one-round result back each cycle. Runs either the full p12 permutation (rounds 0..11) or the reduced p6 permutation (rounds 6..11) under a start/done handshake.

---
 rtl/round_state_reg.sv | 65 ++++++
 tb/tb_round_state_reg.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/round_state_reg.sv
// Ascon state register and round sequencer: loads the state on start, then feeds
// the one-round result back each cycle for p12 (rounds 0..11) or p6 (rounds 6..11).
module round_state_reg (
  input  logic         clock_i,
  input  logic         resetb_i,
  input  logic         start_i,
  input  logic         mode_i,
  input  logic [319:0] state_i,
  input  logic [319:0] round_out_i,
  output logic [319:0] state_o,
  output logic [3:0]   round_o,
  output logic         busy_o,
  output logic         done_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  localparam logic [3:0] ROUND_P12  = 4'd0;
  localparam logic [3:0] ROUND_P6   = 4'd6;
  localparam logic [3:0] ROUND_LAST = 4'd11;

  fsm_t fsm;

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      fsm     <= IDLE;
      state_o <= '0;
      round_o <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (start_i) begin
            state_o <= state_i;
            round_o <= mode_i ? ROUND_P6 : ROUND_P12;
            busy_o  <= 1'b1;
            fsm     <= RUN;
          end
        end
        RUN: begin
          state_o <= round_out_i;
          // The last round leaves round_o parked at 11; it never wraps.
          if (round_o == ROUND_LAST) begin
            busy_o <= 1'b0;
            done_o <= 1'b1;
            fsm    <= DONE;
          end else begin
            round_o <= round_o + 4'd1;
          end
        end
        DONE: begin
          done_o <= 1'b0;
          fsm    <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_round_state_reg.sv
// Randomized self-checking bench for round_state_reg with a stub round function.
module tb_round_state_reg;

  logic         clock_i;
  logic         resetb_i;
  logic         start_i;
  logic         mode_i;
  logic [319:0] state_i;
  logic [319:0] round_out_i;
  logic [319:0] state_o;
  logic [3:0]   round_o;
  logic         busy_o;
  logic         done_o;

  int checks = 0;
  int errors = 0;
  logic stub_sel = 1'b0;  // 0: x2 ^= round constant, 1: x0 += 1

  round_state_reg dut (
    .clock_i     (clock_i),
    .resetb_i    (resetb_i),
    .start_i     (start_i),
    .mode_i      (mode_i),
    .state_i     (state_i),
    .round_out_i (round_out_i),
    .state_o     (state_o),
    .round_o     (round_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  function automatic logic [7:0] rc(input logic [3:0] r);
    logic [7:0] tab [12];
    tab = '{8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
            8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b};
    return (r < 4'd12) ? tab[r] : 8'h00;
  endfunction

  // Word layout: x0 = [319:256], x1, x2 = [191:128], x3, x4 = [63:0].
  function automatic logic [319:0] stub_round(input logic [319:0] s, input logic [3:0] r,
                                              input logic sel);
    logic [319:0] t;
    t = s;
    if (!sel) t[191:128] = s[191:128] ^ {56'd0, rc(r)};
    else      t[319:256] = s[319:256] + 64'd1;
    return t;
  endfunction

  assign round_out_i = stub_round(state_o, round_o, stub_sel);

  function automatic logic [319:0] model_perm(input logic [319:0] s, input logic mode,
                                              input logic sel);
    logic [319:0] t;
    t = s;
    for (int r = (mode ? 6 : 0); r < 12; r++) t = stub_round(t, 4'(r), sel);
    return t;
  endfunction

  function automatic logic [319:0] rand_state();
    logic [319:0] v;
    for (int i = 0; i < 10; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic check_eq(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  // One complete run from an IDLE cycle; hold keeps start_i high with junk through RUN/DONE.
  task automatic do_run(input logic [319:0] s, input logic mode, input logic hold,
                        input logic [319:0] exp);
    int n;
    int busy_cnt;
    logic [3:0] first;
    n = mode ? 6 : 12;
    first = mode ? 4'd6 : 4'd0;
    busy_cnt = 0;
    start_i = 1'b1;
    mode_i  = mode;
    state_i = s;
    step();
    check_eq("load_state", state_o, s);
    check_eq("load_round", 320'(round_o), 320'(first));
    check_eq("load_busy", 320'(busy_o), 320'(1'b1));
    check_eq("load_done", 320'(done_o), 320'(1'b0));
    if (busy_o) busy_cnt++;
    start_i = hold;
    state_i = rand_state();
    mode_i  = ~mode;
    for (int k = 1; k <= n; k++) begin
      step();
      if (k < n) begin
        check_eq("run_round", 320'(round_o), 320'(first + 4'(k)));
        check_eq("run_done", 320'(done_o), 320'(1'b0));
        if (busy_o) busy_cnt++;
      end else begin
        check_eq("fin_done", 320'(done_o), 320'(1'b1));
        check_eq("fin_busy", 320'(busy_o), 320'(1'b0));
        check_eq("fin_round", 320'(round_o), 320'(4'd11));
        check_eq("fin_state", state_o, exp);
      end
    end
    check_eq("busy_cycles", 320'(busy_cnt), 320'(n));
    step();
    check_eq("post_done", 320'(done_o), 320'(1'b0));
    check_eq("post_busy", 320'(busy_o), 320'(1'b0));
    check_eq("post_state", state_o, exp);
    check_eq("post_round", 320'(round_o), 320'(4'd11));
    if (!hold) start_i = 1'b0;
  endtask

  initial begin
    logic [319:0] s;
    logic [319:0] exp;
    logic m;
    logic h;
    start_i  = 1'b0;
    mode_i   = 1'b0;
    state_i  = '0;
    resetb_i = 1'b1;
    #2 resetb_i = 1'b0;
    #2;
    check_eq("rst_state", state_o, '0);
    check_eq("rst_round", 320'(round_o), '0);
    check_eq("rst_busy", 320'(busy_o), '0);
    check_eq("rst_done", 320'(done_o), '0);
    step();
    step();
    resetb_i = 1'b1;

    // p12 and p6 with the round-constant stub.
    stub_sel = 1'b0;
    do_run('0, 1'b0, 1'b0, '0);
    do_run('0, 1'b1, 1'b0, {128'd0, 64'h11, 128'd0});

    // Idle hold after a finished run.
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("idle_state", state_o, {128'd0, 64'h11, 128'd0});
      check_eq("idle_round", 320'(round_o), 320'(4'd11));
      check_eq("idle_done", 320'(done_o), '0);
    end

    // Round count with the x0+1 stub.
    stub_sel = 1'b1;
    do_run({64'h100, 256'd0}, 1'b0, 1'b0, {64'h10c, 256'd0});
    do_run({64'h100, 256'd0}, 1'b1, 1'b0, {64'h106, 256'd0});

    // Start held through RUN and DONE, then back-to-back runs at minimum spacing.
    stub_sel = 1'b0;
    do_run('0, 1'b0, 1'b1, '0);
    do_run('0, 1'b1, 1'b1, {128'd0, 64'h11, 128'd0});
    do_run('0, 1'b0, 1'b0, '0);

    // Reset after E5 of a p12 run.
    start_i = 1'b1;
    mode_i  = 1'b0;
    state_i = '0;
    step();
    start_i = 1'b0;
    for (int i = 0; i < 5; i++) step();
    resetb_i = 1'b0;
    #1;
    check_eq("mid_rst_state", state_o, '0);
    check_eq("mid_rst_round", 320'(round_o), '0);
    check_eq("mid_rst_busy", 320'(busy_o), '0);
    for (int i = 0; i < 9; i++) begin
      step();
      check_eq("mid_rst_done", 320'(done_o), '0);
    end
    resetb_i = 1'b1;
    do_run({64'h100, 256'd0}, 1'b0, 1'b0, {64'h100, 64'd0, 64'h0, 128'd0});

    // Randomized runs against the model.
    for (int it = 0; it < 20; it++) begin
      s = rand_state();
      m = 1'($urandom_range(0, 1));
      h = 1'($urandom_range(0, 1));
      stub_sel = 1'($urandom_range(0, 1));
      exp = model_perm(s, m, stub_sel);
      do_run(s, m, h, exp);
    end
    start_i = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
